fetch_sequencer: RTL and testbench

//  Drives the instruction cache read port (rd_dest/rd_en/nop) as the front-end fetch controller.

---
 rtl/fetch_sequencer.sv | 103 ++++++++++
 tb/tb_fetch_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Front-end fetch controller driving the i-cache read port.
// Sequences the PC, holds on stall, redirects with one bubble, halts on HALT.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        resume,
  input  logic [15:0] icache_rd_out,
  input  logic [15:0] icache_pc_out,
  output logic [15:0] icache_rd_dest,
  output logic        icache_rd_en,
  output logic        icache_nop,
  output logic        instr_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } state_t;

  state_t      state;
  logic [15:0] fetch_pc;
  logic        valid_q;
  logic        halt_hit;

  // icache_pc_out is informational only; decode consumes it directly
  logic        unused_pc;
  assign unused_pc = ^icache_pc_out;

  assign halt_hit       = valid_q && (icache_rd_out == HALT_INSTR);
  assign icache_rd_dest = fetch_pc;
  assign instr_valid    = valid_q;
  assign halted         = (state == HALT);

  always_comb begin
    icache_rd_en = 1'b0;
    icache_nop   = 1'b1;
    if (!rst) begin
      case (state)
        FETCH: begin
          priority case (1'b1)
            redirect_valid: icache_nop = 1'b1;
            stall:          icache_nop = 1'b0;
            halt_hit:       icache_nop = 1'b1;
            default: begin
              icache_rd_en = 1'b1;
              icache_nop   = 1'b0;
            end
          endcase
        end
        HALT:    icache_nop = 1'b0;
        default: icache_nop = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      valid_q     <= 1'b0;
      fetch_count <= 16'h0000;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            valid_q  <= 1'b0;
          end else if (stall) begin
            valid_q  <= valid_q;
          end else if (halt_hit) begin
            valid_q  <= 1'b0;
            state    <= HALT;
          end else begin
            fetch_pc <= fetch_pc + 16'd1;
            valid_q  <= 1'b1;
            if (fetch_count != 16'hFFFF)
              fetch_count <= fetch_count + 16'd1;
          end
        end
        HALT: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            state    <= FETCH;
          end else if (resume) begin
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural i-cache plus reference fetch model.
// Directed scenarios first, then randomized stall/redirect/resume/reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        resume = 1'b0;
  logic [15:0] c_rd;
  logic [15:0] c_pc;
  logic [15:0] dest;
  logic        en;
  logic        nop;
  logic        iv;
  logic        hl;
  logic [15:0] count;

  logic [15:0] mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_run, m_halt, m_valid;
  logic [15:0] m_pc, m_last, m_count;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .resume         (resume),
    .icache_rd_out  (c_rd),
    .icache_pc_out  (c_pc),
    .icache_rd_dest (dest),
    .icache_rd_en   (en),
    .icache_nop     (nop),
    .instr_valid    (iv),
    .halted         (hl),
    .fetch_count    (count)
  );

  always #5 clk = ~clk;

  // 1-cycle cache: nop forces zero, rd_en loads, otherwise holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rd <= 16'h0000;
      c_pc <= 16'h0000;
    end else if (nop) begin
      c_rd <= 16'h0000;
    end else if (en) begin
      c_rd <= mem[dest];
      c_pc <= dest;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_halt  = 1'b0;
    m_valid = 1'b0;
    m_pc    = 16'h0000;
    m_last  = 16'h0000;
    m_count = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    resume         = 1'b0;
    rst            = 1'b1;
    #1;
    chk("rst_en", en, 1'b0);
    chk("rst_nop", nop, 1'b1);
    chk("rst_dest", dest, 16'h0000);
    chk("rst_valid", iv, 1'b0);
    chk("rst_halted", hl, 1'b0);
    chk("rst_count", count, 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input logic s, input logic r,
                      input logic [15:0] rp, input logic res);
    logic        e_en, e_nop;
    bit          n_halt, n_valid;
    logic [15:0] n_pc, n_last, n_count;
    @(negedge clk);
    stall          = s;
    redirect_valid = r;
    redirect_pc    = rp;
    resume         = res;
    #1;
    e_en    = 1'b0;
    e_nop   = 1'b1;
    n_halt  = m_halt;
    n_valid = m_valid;
    n_pc    = m_pc;
    n_last  = m_last;
    n_count = m_count;
    if (!m_run) begin
      e_nop = 1'b1;
    end else if (m_halt) begin
      e_nop = 1'b0;
      if (r) begin
        n_pc   = rp;
        n_halt = 1'b0;
      end else if (res) begin
        n_halt = 1'b0;
      end
    end else if (r) begin
      n_pc    = rp;
      n_valid = 1'b0;
    end else if (s) begin
      e_nop = 1'b0;
    end else if (m_valid && mem[m_last] == 16'hFFFF) begin
      n_valid = 1'b0;
      n_halt  = 1'b1;
    end else begin
      e_en    = 1'b1;
      e_nop   = 1'b0;
      n_last  = m_pc;
      n_pc    = m_pc + 16'd1;
      n_valid = 1'b1;
      if (m_count != 16'hFFFF) n_count = m_count + 16'd1;
    end
    chk("rd_en", en, e_en);
    chk("nop", nop, e_nop);
    chk("rd_dest", dest, m_pc);
    chk("instr_valid", iv, m_valid);
    chk("halted", hl, m_halt);
    chk("fetch_count", count, m_count);
    if (m_valid) begin
      chk("pc_out", c_pc, m_last);
      chk("rd_out", c_rd, mem[m_last]);
    end
    @(posedge clk);
    m_run   = 1'b1;
    m_halt  = n_halt;
    m_valid = n_valid;
    m_pc    = n_pc;
    m_last  = n_last;
    m_count = n_count;
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      mem[i] = (w == 16'hFFFF) ? 16'h1234 : w;
    end
    mem[0]      = 16'h1111;
    mem[1]      = 16'h2222;
    mem[2]      = 16'h3333;
    mem[3]      = 16'h4444;
    mem[5]      = 16'hFFFF;
    mem[16]     = 16'hFFFF;
    mem[16'h100] = 16'hABCD;

    do_reset();

    // idle, then sequential fetch of 0..2
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    #1;
    chk("stall_rd_out", c_rd, 16'h3333);
    chk("stall_dest", dest, 16'h0003);
    chk("stall_valid", iv, 1'b1);
    step(0, 0, 0, 0);
    #1;
    chk("seq_rd_out", c_rd, 16'h4444);
    chk("seq_count", count, 16'd4);

    // fetch 4 and 5, then the HALT word is seen
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    #1;
    chk("halt_flag", hl, 1'b1);
    chk("halt_dest", dest, 16'h0006);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    #1;
    chk("resume_pc_out", c_pc, 16'h0006);

    step(0, 1, 16'h0100, 0);
    #1;
    chk("bubble_rd_out", c_rd, 16'h0000);
    chk("bubble_valid", iv, 1'b0);
    chk("bubble_dest", dest, 16'h0100);
    step(0, 0, 0, 0);
    #1;
    chk("redir_rd_out", c_rd, 16'hABCD);
    chk("redir_valid", iv, 1'b1);

    // redirect beats a simultaneous stall; then wrap past 0xFFFF
    step(1, 1, 16'hFFFF, 0);
    #1;
    chk("redir_stall_dest", dest, 16'hFFFF);
    step(0, 0, 0, 0);
    #1;
    chk("wrap_dest", dest, 16'h0000);
    step(0, 0, 0, 0);
    #1;
    chk("wrap_pc_out", c_pc, 16'h0000);
    step(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      logic        rs, rr, rres;
      logic [15:0] rpc;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        rs   = ($urandom_range(0, 3) == 0);
        rr   = ($urandom_range(0, 9) == 0);
        rres = ($urandom_range(0, 4) == 0);
        rpc  = $urandom_range(0, 1) ? 16'($urandom_range(0, 40))
                                    : 16'(16'hFFF8 + $urandom_range(0, 7));
        step(rs, rr, rpc, rres);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
